adder_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares a single two-operand adder tile among NUM_REQ AXI-Stream requesters. It sits directly upstream of the adder's slave port. It locks a grant for a whole packet, from the first beat through the TLAST beat, so operand pairs are never interleaved. It tags each forwarded beat's TID with the source port index so results can be routed back. The output goes through one register stage for timing isolation.

---
 rtl/adder_arbiter_pkg.sv | 10 +
 rtl/adder_arbiter_rr_pick.sv | 27 ++
 rtl/adder_arbiter.sv | 105 ++++++++++
 tb/tb_adder_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_arbiter_pkg.sv
// adder_arbiter_pkg: shared types and helpers for the packet round-robin arbiter
package adder_arbiter_pkg;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

    function automatic int rr_next(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/adder_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority picker
//   req : request vector, one bit per port
//   ptr : highest-priority port index
//   any : at least one request is set
//   idx : first requesting port scanning upward from ptr, modulo NUM_REQ
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic               any,
    output logic [PW-1:0]      idx
);
    // Scan farthest offset first so the nearest requester overwrites last.
    always_comb begin
        logic [PW-1:0] j;
        any = |req;
        idx = '0;
        j   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = PW'((int'(ptr) + k) % NUM_REQ);
            if (req[j]) idx = j;
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: packet-locked round-robin arbiter feeding a shared adder tile
//   CLK, RST                 : clock, async active-high reset
//   AXIS_S_*                 : NUM_REQ packed requester streams (TVALID/TREADY/TDATA/TLAST/TDEST)
//   AXIS_M_*                 : registered stream toward the adder; TID carries the source port
//   GRANT_VALID, GRANT_IDX   : lock status and locked port (0 when idle)
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TDATAW  = 32,
    parameter int TDESTW  = 4,
    parameter int TIDW    = 2
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NUM_REQ-1:0]        AXIS_S_TVALID,
    output logic [NUM_REQ-1:0]        AXIS_S_TREADY,
    input  logic [NUM_REQ*TDATAW-1:0] AXIS_S_TDATA,
    input  logic [NUM_REQ-1:0]        AXIS_S_TLAST,
    input  logic [NUM_REQ*TDESTW-1:0] AXIS_S_TDEST,
    output logic                      AXIS_M_TVALID,
    input  logic                      AXIS_M_TREADY,
    output logic [TDATAW-1:0]         AXIS_M_TDATA,
    output logic                      AXIS_M_TLAST,
    output logic [TIDW-1:0]           AXIS_M_TID,
    output logic [TDESTW-1:0]         AXIS_M_TDEST,
    output logic                      GRANT_VALID,
    output logic [TIDW-1:0]           GRANT_IDX
);
    localparam int PW = $clog2(NUM_REQ);

    arb_state_t        state, state_n;
    logic [PW-1:0]     rr_ptr, rr_ptr_n, grant, grant_n, winner, sel;
    logic              any, out_ready, s_hs, s_last;
    logic [TDATAW-1:0] s_data [NUM_REQ];
    logic [TDESTW-1:0] s_dest [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign s_data[i] = AXIS_S_TDATA[i*TDATAW +: TDATAW];
        assign s_dest[i] = AXIS_S_TDEST[i*TDESTW +: TDESTW];
    end

    rr_pick #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick (
        .req (AXIS_S_TVALID),
        .ptr (rr_ptr),
        .any (any),
        .idx (winner)
    );

    assign out_ready = !AXIS_M_TVALID || AXIS_M_TREADY;
    assign sel       = (state == ARB_LOCKED) ? grant : winner;
    assign s_hs      = |(AXIS_S_TVALID & AXIS_S_TREADY);
    assign s_last    = AXIS_S_TLAST[sel];

    // Ready is masked during reset so no beat can be accepted while the register is held clear.
    always_comb begin
        AXIS_S_TREADY = '0;
        if (!RST && (state == ARB_LOCKED || any)) AXIS_S_TREADY[sel] = out_ready;
    end

    always_comb begin
        state_n  = state;
        grant_n  = grant;
        rr_ptr_n = rr_ptr;
        if (s_hs) begin
            state_n  = s_last ? ARB_IDLE : ARB_LOCKED;
            grant_n  = s_last ? grant : sel;
            rr_ptr_n = s_last ? PW'(rr_next(int'(sel), NUM_REQ)) : rr_ptr;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= ARB_IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_n;
            grant  <= grant_n;
            rr_ptr <= rr_ptr_n;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            AXIS_M_TVALID <= 1'b0;
            AXIS_M_TDATA  <= '0;
            AXIS_M_TLAST  <= 1'b0;
            AXIS_M_TID    <= '0;
            AXIS_M_TDEST  <= '0;
        end else if (s_hs) begin
            AXIS_M_TVALID <= 1'b1;
            AXIS_M_TDATA  <= s_data[sel];
            AXIS_M_TLAST  <= s_last;
            AXIS_M_TID    <= TIDW'(sel);
            AXIS_M_TDEST  <= s_dest[sel];
        end else if (AXIS_M_TREADY) begin
            AXIS_M_TVALID <= 1'b0;
        end
    end

    assign GRANT_VALID = state == ARB_LOCKED;
    assign GRANT_IDX   = (state == ARB_LOCKED) ? TIDW'(grant) : '0;

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed and random checks of adder_arbiter against a cycle model
module tb_adder_arbiter;
    typedef struct packed {logic [31:0] d; logic l; logic [3:0] t;} beat_t;
    typedef struct packed {logic [1:0] tid; logic l; logic [31:0] d;} ob_t;

    logic         clk = 0, rst = 0;
    logic [3:0]   s_valid = 0, s_ready, s_last = 0;
    logic [127:0] s_data = 0;
    logic [15:0]  s_dest = 0;
    logic         m_valid, m_ready = 0, m_last, g_valid;
    logic [31:0]  m_data;
    logic [1:0]   m_tid, g_idx;
    logic [3:0]   m_dest;

    beat_t q[4][$];
    ob_t   log[$];
    logic [3:0] hold = 0;
    int vectors = 0, errors = 0;

    int lock, ptr;
    logic ov, last;
    logic [31:0] data;
    logic [1:0] tid;
    logic [3:0] dest;

    adder_arbiter dut (
        .CLK(clk), .RST(rst),
        .AXIS_S_TVALID(s_valid), .AXIS_S_TREADY(s_ready), .AXIS_S_TDATA(s_data),
        .AXIS_S_TLAST(s_last), .AXIS_S_TDEST(s_dest),
        .AXIS_M_TVALID(m_valid), .AXIS_M_TREADY(m_ready), .AXIS_M_TDATA(m_data),
        .AXIS_M_TLAST(m_last), .AXIS_M_TID(m_tid), .AXIS_M_TDEST(m_dest),
        .GRANT_VALID(g_valid), .GRANT_IDX(g_idx)
    );

    initial forever #5 clk = ~clk;

    task automatic drive();
        for (int p = 0; p < 4; p++) begin
            s_valid[p] = q[p].size() > 0 && !hold[p];
            if (q[p].size() > 0) begin
                s_data[p*32 +: 32] = q[p][0].d;
                s_last[p]          = q[p][0].l;
                s_dest[p*4 +: 4]   = q[p][0].t;
            end
        end
    endtask

    task automatic apply_reset();
        rst = 1;
        for (int p = 0; p < 4; p++) q[p].delete();
        log.delete();
        hold = 0;
        lock = -1; ptr = 0; ov = 0; last = 0; data = 0; tid = 0; dest = 0;
        drive();
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    // One clock: model computes the expected ready/registers, then advances past the edge.
    task automatic step();
        int win;
        logic ordy, hs;
        logic [3:0] er;
        drive();
        #1;
        ordy = !ov || m_ready;
        win = -1;
        if (lock >= 0) win = lock;
        else for (int k = 0; k < 4; k++) if (win < 0 && s_valid[(ptr + k) % 4]) win = (ptr + k) % 4;
        er = (win >= 0 && ordy) ? 4'(1 << win) : 4'd0;
        hs = win >= 0 && ordy && s_valid[win];
        vectors++;
        if (s_ready !== er) begin
            errors++;
            $display("FAIL s_ready: got %b want %b", s_ready, er);
        end
        vectors++;
        if ({m_valid, m_last, m_tid, m_dest, m_data} !== {ov, last, tid, dest, data}) begin
            errors++;
            $display("FAIL m_out: got v%b l%b id%0d dst%h d%h want v%b l%b id%0d dst%h d%h",
                     m_valid, m_last, m_tid, m_dest, m_data, ov, last, tid, dest, data);
        end
        vectors++;
        if ({g_valid, g_idx} !== {lock >= 0, lock >= 0 ? 2'(lock) : 2'd0}) begin
            errors++;
            $display("FAIL grant: got %b/%0d want lock %0d", g_valid, g_idx, lock);
        end
        if (m_valid && m_ready) log.push_back({m_tid, m_last, m_data});
        @(posedge clk);
        if (hs) begin
            ov = 1; data = q[win][0].d; last = q[win][0].l; dest = q[win][0].t; tid = 2'(win);
            void'(q[win].pop_front());
            if (last) begin
                lock = -1;
                ptr = (win + 1) % 4;
            end else lock = win;
        end else if (m_ready) ov = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        s_valid = 4'hF;
        m_ready = 1;
        rst = 1;
        #1;
        vectors++;
        if ({m_valid, m_last, m_tid, m_dest, m_data} !== '0) begin
            errors++;
            $display("FAIL reset_m: got v%b l%b id%0d dst%h d%h want 0", m_valid, m_last, m_tid, m_dest, m_data);
        end
        vectors++;
        if ({s_ready, g_valid, g_idx} !== '0) begin
            errors++;
            $display("FAIL reset_ctl: got rdy%b gv%b gi%0d want 0", s_ready, g_valid, g_idx);
        end
        apply_reset();
    endtask

    task automatic test_single_packet();
        apply_reset();
        m_ready = 1;
        q[2].push_back({32'd5, 1'b0, 4'hA});
        q[2].push_back({32'd7, 1'b1, 4'hA});
        step();
        #1;
        vectors++;
        if ({g_valid, g_idx} !== 3'b110) begin
            errors++;
            $display("FAIL single_grant: got %b/%0d want 1/2", g_valid, g_idx);
        end
        repeat (3) step();
        vectors++;
        if (log.size() != 2 || log[0] !== {2'd2, 1'b0, 32'd5} || log[1] !== {2'd2, 1'b1, 32'd7}) begin
            errors++;
            $display("FAIL single_beats: got %0d beats want 5,7 from port 2", log.size());
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        m_ready = 1;
        for (int p = 0; p < 4; p++) begin
            q[p].push_back({32'(p * 16), 1'b0, 4'(p)});
            q[p].push_back({32'(p * 16 + 1), 1'b1, 4'(p)});
        end
        q[0].push_back({32'd100, 1'b0, 4'd0});
        q[0].push_back({32'd101, 1'b1, 4'd0});
        repeat (10) step();
        vectors++;
        if (log.size() != 9) begin
            errors++;
            $display("FAIL rr_count: got %0d beats want 9", log.size());
        end
        for (int i = 0; i < 8 && i < log.size(); i++) begin
            vectors++;
            if (log[i].tid !== 2'(i / 2) || log[i].d !== 32'((i / 2) * 16 + i % 2)) begin
                errors++;
                $display("FAIL rr_order[%0d]: got id%0d d%0d want id%0d d%0d",
                         i, log[i].tid, log[i].d, i / 2, (i / 2) * 16 + i % 2);
            end
        end
        if (log.size() > 8) begin
            vectors++;
            if (log[8].tid !== 2'd0 || log[8].d !== 32'd100) begin
                errors++;
                $display("FAIL rr_wrap: got id%0d d%0d want id0 d100", log[8].tid, log[8].d);
            end
        end
    endtask

    task automatic test_lock_hold();
        apply_reset();
        m_ready = 1;
        q[1].push_back({32'd20, 1'b0, 4'd1});
        q[1].push_back({32'd21, 1'b0, 4'd1});
        q[1].push_back({32'd22, 1'b1, 4'd1});
        q[3].push_back({32'd30, 1'b0, 4'd3});
        q[3].push_back({32'd31, 1'b1, 4'd3});
        step();
        hold[1] = 1;
        repeat (3) begin
            step();
            #1;
            vectors++;
            if (s_ready[3] !== 1'b0 || g_valid !== 1'b1 || g_idx !== 2'd1) begin
                errors++;
                $display("FAIL lock_hold: got rdy%b gv%b gi%0d want port3 stalled, lock 1", s_ready, g_valid, g_idx);
            end
        end
        hold[1] = 0;
        repeat (2) step();
        drive();
        #1;
        vectors++;
        if (s_ready !== 4'b1000) begin
            errors++;
            $display("FAIL lock_next: got %b want 1000", s_ready);
        end
        repeat (4) step();
        vectors++;
        if (log.size() != 5 || log[2].tid !== 2'd1 || log[3].tid !== 2'd3 || log[4].d !== 32'd31) begin
            errors++;
            $display("FAIL lock_seq: got %0d beats want 20,21,22 then 30,31", log.size());
        end
    endtask

    task automatic test_stall();
        logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        apply_reset();
        for (int i = 0; i < 4; i++) q[0].push_back({32'(40 + i), i == 3, 4'h5});
        for (int i = 0; i < 16; i++) begin
            m_ready = pat[i % 4];
            step();
        end
        vectors++;
        if (log.size() != 4) begin
            errors++;
            $display("FAIL stall_count: got %0d beats want 4", log.size());
        end
        for (int i = 0; i < 4 && i < log.size(); i++) begin
            vectors++;
            if (log[i].d !== 32'(40 + i)) begin
                errors++;
                $display("FAIL stall_data[%0d]: got %0d want %0d", i, log[i].d, 40 + i);
            end
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        m_ready = 1;
        q[3].push_back({32'd50, 1'b1, 4'd3});
        step();
        q[0].push_back({32'd60, 1'b1, 4'd0});
        q[3].push_back({32'd51, 1'b1, 4'd3});
        repeat (4) step();
        vectors++;
        if (log.size() != 3 || log[0].tid !== 2'd3 || log[1].tid !== 2'd0 || log[2].tid !== 2'd3) begin
            errors++;
            $display("FAIL wrap_order: got %0d beats, want ids 3,0,3", log.size());
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        m_ready = 1;
        for (int i = 0; i < 3; i++) q[0].push_back({32'(80 + i), i == 2, 4'h8});
        repeat (2) step();
        drive();
        rst = 1;
        #1;
        vectors++;
        if ({m_valid, m_last, m_tid, m_dest, m_data, s_ready, g_valid, g_idx} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got v%b d%h rdy%b gv%b gi%0d want all 0", m_valid, m_data, s_ready, g_valid, g_idx);
        end
        apply_reset();
        q[1].push_back({32'd70, 1'b0, 4'd1});
        q[1].push_back({32'd71, 1'b1, 4'd1});
        repeat (4) step();
        vectors++;
        if (log.size() != 2 || log[0] !== {2'd1, 1'b0, 32'd70} || log[1] !== {2'd1, 1'b1, 32'd71}) begin
            errors++;
            $display("FAIL reset_after: got %0d beats want 70,71 from port 1", log.size());
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < 4; p++) begin
                if (q[p].size() == 0) begin
                    int len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++) q[p].push_back({$urandom(), b == len - 1, 4'($urandom)});
                end
                if (!s_valid[p]) hold[p] = $urandom_range(0, 2) == 0;
            end
            m_ready = $urandom_range(0, 3) != 0;
            step();
        end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_lock_hold();
        test_stall();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
